// File: rtl/alu_exec_controller.sv
// ALU execution controller: debounced operand/op buttons, SPI operand A,
// FSM-sequenced MUL/SUB/AND/XOR with flags, valid/ready reply and motor PWM.
module alu_exec_controller #(
  parameter int WIDTH    = 4,
  parameter int DEB_N    = 16,
  parameter int PWM_BITS = 8
) (
  input  logic             FPGA_clk,
  input  logic             FPGA_reset,
  input  logic [WIDTH-1:0] spi_data_in,
  input  logic             spi_valid_in,
  input  logic [3:0]       btn_operand_n,
  input  logic [3:0]       btn_op,
  input  logic             tx_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic [3:0]       flags_out,
  output logic             result_valid_out,
  output logic [WIDTH-1:0] tx_data_out,
  output logic             tx_valid_out,
  output logic             busy_out,
  output logic             motor_pwm
);

  localparam int unsigned NBTN = 8;
  localparam int unsigned MCW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_SEND} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_SUB, OP_AND, OP_XOR} op_t;

  // Button levels in "pressed = 1" polarity: [3:0] operand, [7:4] op.
  logic [NBTN-1:0]  raw_level;
  logic [NBTN-1:0]  sync_a, sync_b;
  logic [NBTN-1:0]  deb_level, deb_prev, press;
  logic [DEB_N-1:0] deb_cnt [NBTN];

  logic             opnd_hit, op_hit;
  logic [1:0]       opnd_idx, op_idx;

  logic [WIDTH-1:0] a_reg, b_reg;

  state_t           state, next_state;
  logic             launch, finish;
  op_t              w_op;
  logic [WIDTH-1:0] w_a, w_b, mplier;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [MCW-1:0]   mul_cnt;
  logic             mul_done;

  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  logic [PWM_BITS-1:0] pwm_cnt, duty;

  assign raw_level = {btn_op, ~btn_operand_n};

  // Two-flop synchroniser for all raw buttons.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_level;
      sync_b <= sync_a;
    end
  end

  // Per-button debounce: accept a new level after 2^DEB_N differing cycles.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      deb_level <= '0;
      for (int unsigned i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync_b[i] == deb_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == '1) begin
          deb_level[i] <= sync_b[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) deb_prev <= '0;
    else            deb_prev <= deb_level;
  end

  assign press = deb_level & ~deb_prev;

  // Lowest-index priority encoders for operand and op presses.
  always_comb begin
    opnd_hit = 1'b0;
    opnd_idx = '0;
    op_hit   = 1'b0;
    op_idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (press[i] && !opnd_hit) begin
        opnd_hit = 1'b1;
        opnd_idx = 2'(i);
      end
      if (press[4+i] && !op_hit) begin
        op_hit = 1'b1;
        op_idx = 2'(i);
      end
    end
  end

  // Operand registers: A from SPI (always accepted), B from operand buttons.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (spi_valid_in) a_reg <= spi_data_in;
      if (opnd_hit)     b_reg <= WIDTH'(opnd_idx);
    end
  end

  // FSM state register.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) state <= S_IDLE;
    else            state <= next_state;
  end

  // MUL stays one extra cycle after its WIDTH shift-add steps to publish.
  assign mul_done = (mul_cnt == MCW'(WIDTH));

  // Next-state and launch/finish strobes.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_hit) begin
          launch     = 1'b1;
          next_state = (op_t'(op_idx) == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        finish     = 1'b1;
        next_state = S_SEND;
      end
      S_MUL: begin
        if (mul_done) begin
          finish     = 1'b1;
          next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_valid_out && tx_ready_in) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign busy_out = (state != S_IDLE);

  // Working registers and iterative shift-add multiplier.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      w_a     <= '0;
      w_b     <= '0;
      w_op    <= OP_MUL;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mul_cnt <= '0;
    end else if (launch) begin
      w_a     <= a_reg;
      w_b     <= b_reg;
      w_op    <= op_t'(op_idx);
      acc     <= '0;
      mcand   <= (2*WIDTH)'(a_reg);
      mplier  <= b_reg;
      mul_cnt <= '0;
    end else if (state == S_MUL && !mul_done) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  // Result and carry/overflow for the captured operation.
  always_comb begin
    sub_full = {1'b0, w_a} - {1'b0, w_b};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (w_op)
      OP_MUL: begin
        alu_res = acc[WIDTH-1:0];
        alu_c   = |acc[2*WIDTH-1:WIDTH];
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (w_a[WIDTH-1] ^ w_b[WIDTH-1]) & (sub_full[WIDTH-1] ^ w_a[WIDTH-1]);
      end
      OP_AND:  alu_res = w_a & w_b;
      OP_XOR:  alu_res = w_a ^ w_b;
      default: alu_res = '0;
    endcase
  end

  // Result/flags publication and reply handshake.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      result_out       <= '0;
      flags_out        <= '0;
      result_valid_out <= 1'b0;
      tx_data_out      <= '0;
      tx_valid_out     <= 1'b0;
    end else begin
      result_valid_out <= finish;
      if (finish) begin
        result_out   <= alu_res;
        flags_out    <= {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
        tx_data_out  <= alu_res;
        tx_valid_out <= 1'b1;
      end else if (tx_valid_out && tx_ready_in) begin
        tx_valid_out <= 1'b0;
      end
    end
  end

  // Free-running PWM; duty only reloads at wrap so each period is whole.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      pwm_cnt   <= '0;
      duty      <= '0;
      motor_pwm <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) duty <= PWM_BITS'(result_out) << (PWM_BITS - WIDTH);
      motor_pwm <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_alu_exec_controller.sv
// Bench for alu_exec_controller: directed scenarios plus randomized buttons,
// SPI and ready, checked each cycle against a behavioural model.
module tb_alu_exec_controller;

  localparam int W  = 4;
  localparam int DN = 2;
  localparam int PB = 8;
  localparam int HD = (1 << DN) + 2;

  logic         clk = 1'b0;
  logic         FPGA_reset = 1'b0;
  logic [W-1:0] spi_data_in = '0;
  logic         spi_valid_in = 1'b0;
  logic [3:0]   btn_operand_n = 4'hF;
  logic [3:0]   btn_op = 4'h0;
  logic         tx_ready_in = 1'b1;
  logic [W-1:0] result_out;
  logic [3:0]   flags_out;
  logic         result_valid_out;
  logic [W-1:0] tx_data_out;
  logic         tx_valid_out;
  logic         busy_out;
  logic         motor_pwm;

  int checks = 0;
  int errors = 0;

  alu_exec_controller #(.WIDTH(W), .DEB_N(DN), .PWM_BITS(PB)) dut (
    .FPGA_clk        (clk),
    .FPGA_reset      (FPGA_reset),
    .spi_data_in     (spi_data_in),
    .spi_valid_in    (spi_valid_in),
    .btn_operand_n   (btn_operand_n),
    .btn_op          (btn_op),
    .tx_ready_in     (tx_ready_in),
    .result_out      (result_out),
    .flags_out       (flags_out),
    .result_valid_out(result_valid_out),
    .tx_data_out     (tx_data_out),
    .tx_valid_out    (tx_valid_out),
    .busy_out        (busy_out),
    .motor_pwm       (motor_pwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns (flags << W) | result, from plain integer arithmetic.
  function automatic int alu(input int op, input int a, input int b);
    int m = 1 << W;
    int half = 1 << (W - 1);
    int r = 0, c = 0, v = 0, sa, sb, d, p;
    case (op)
      0: begin p = a * b; r = p % m; c = (p >= m) ? 1 : 0; end
      1: begin
        r = (a - b + m) % m;
        c = (a < b) ? 1 : 0;
        sa = (a >= half) ? a - m : a;
        sb = (b >= half) ? b - m : b;
        d = sa - sb;
        v = (d < -half || d > half - 1) ? 1 : 0;
      end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    return ((((r >= half) ? 8 : 0) + v * 4 + c * 2 + ((r == 0) ? 1 : 0)) << W) | r;
  endfunction

  // Behavioural model state.
  bit [7:0] hist [HD];
  bit [7:0] m_deb, m_press;
  int m_a, m_b, m_busy, m_left, m_res, m_flags, m_rv, m_txv, m_txd;
  int m_pwm, m_pcnt, m_duty, pend_r, pend_f;

  always @(posedge clk or posedge FPGA_reset) begin : model
    bit [7:0] old_deb;
    bit [7:0] raw;
    int busy_pre, op_i, opnd_i, v;
    bit all_diff;
    if (FPGA_reset) begin
      for (int k = 0; k < HD; k++) hist[k] = '0;
      m_deb = '0; m_press = '0;
      m_a = 0; m_b = 0; m_busy = 0; m_left = 0; m_res = 0; m_flags = 0;
      m_rv = 0; m_txv = 0; m_txd = 0; m_pwm = 0; m_pcnt = 0; m_duty = 0;
      pend_r = 0; pend_f = 0;
    end else begin
      m_pwm = (m_pcnt < m_duty) ? 1 : 0;
      if (m_pcnt == (1 << PB) - 1) m_duty = m_res * (1 << (PB - W));
      m_pcnt = (m_pcnt + 1) % (1 << PB);

      busy_pre = m_busy;
      m_rv = 0;
      if (m_txv != 0 && tx_ready_in) begin m_txv = 0; m_busy = 0; end
      if (m_busy != 0 && m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res = pend_r; m_flags = pend_f; m_txd = pend_r; m_rv = 1; m_txv = 1;
        end
      end

      op_i = -1; opnd_i = -1;
      for (int i = 3; i >= 0; i--) begin
        if (m_press[4 + i]) op_i = i;
        if (m_press[i]) opnd_i = i;
      end
      if (busy_pre == 0 && op_i >= 0) begin
        v = alu(op_i, m_a, m_b);
        pend_r = v % (1 << W);
        pend_f = v >> W;
        m_busy = 1;
        m_left = (op_i == 0) ? W + 1 : 1;
      end
      if (opnd_i >= 0) m_b = opnd_i;
      if (spi_valid_in) m_a = int'(spi_data_in);

      raw = {btn_op, ~btn_operand_n};
      for (int k = HD - 1; k > 0; k--) hist[k] = hist[k - 1];
      hist[0] = raw;
      old_deb = m_deb;
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        for (int k = 2; k < HD; k++) if (hist[k][b] == old_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~old_deb[b];
      end
      m_press = m_deb & ~old_deb;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("result_out", int'(result_out), m_res);
    chk("flags_out", int'(flags_out), m_flags);
    chk("result_valid_out", int'(result_valid_out), m_rv);
    chk("tx_data_out", int'(tx_data_out), m_txd);
    chk("tx_valid_out", int'(tx_valid_out), m_txv);
    chk("busy_out", int'(busy_out), m_busy);
    chk("motor_pwm", int'(motor_pwm), m_pwm);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_a(input int v);
    spi_data_in = W'(v);
    spi_valid_in = 1'b1;
    @(negedge clk);
    spi_valid_in = 1'b0;
  endtask

  task automatic press_opnd(input int i);
    btn_operand_n[i] = 1'b0;
    cyc(10);
    btn_operand_n[i] = 1'b1;
    cyc(10);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_result"}, int'(result_out), 0);
    chk({tag, "_flags"}, int'(flags_out), 0);
    chk({tag, "_rv"}, int'(result_valid_out), 0);
    chk({tag, "_txd"}, int'(tx_data_out), 0);
    chk({tag, "_txv"}, int'(tx_valid_out), 0);
    chk({tag, "_busy"}, int'(busy_out), 0);
    chk({tag, "_pwm"}, int'(motor_pwm), 0);
  endtask

  task automatic run_op(input int op, input int exp_r, input int exp_f,
                        input int exp_lat, input bit inject);
    int n;
    btn_op[op] = 1'b1;
    n = 0;
    while (!busy_out && n < 40) begin @(negedge clk); n++; end
    chk("launch", int'(busy_out), 1);
    n = 0;
    while (!result_valid_out && n < 20) begin
      spi_valid_in = inject && (n == 0);
      if (inject) spi_data_in = 4'hF;
      @(negedge clk);
      n++;
    end
    spi_valid_in = 1'b0;
    chk("latency", n, exp_lat);
    chk("op_result", int'(result_out), exp_r);
    chk("op_flags", int'(flags_out), exp_f);
    chk("op_tx_data", int'(tx_data_out), exp_r);
    chk("op_tx_valid", int'(tx_valid_out), 1);
    btn_op[op] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 60) begin @(negedge clk); n++; end
    chk("idle", int'(busy_out), 0);
    cyc(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    #1 FPGA_reset = 1'b1;
    #1 all_zero("reset");
    cyc(3);
    FPGA_reset = 1'b0;

    // Idle buttons: nothing may happen.
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(result_valid_out); end
    chk("idle_no_valid", cnt, 0);

    // Bounce shorter than the debounce window is rejected.
    btn_op[1] = 1'b1; cyc(3);
    btn_op[1] = 1'b0; cyc(1);
    btn_op[1] = 1'b1; cyc(2);
    btn_op[1] = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(busy_out); end
    chk("bounce_reject", cnt, 0);

    // Stable press: debounced at edge 6, launch visible after edge 7.
    btn_op[1] = 1'b1;
    n = 0;
    while (!busy_out && n < 30) begin @(negedge clk); n++; end
    chk("deb_latency", n, 7);
    n = 0;
    while (!result_valid_out && n < 20) begin @(negedge clk); n++; end
    chk("zero_sub_result", int'(result_out), 0);
    chk("zero_sub_flags", int'(flags_out), 4'b0001);
    btn_op[1] = 1'b0;
    wait_idle();

    // SUB overflow: 9 - 2.
    load_a(9); press_opnd(2);
    run_op(1, 7, 4'b0100, 1, 1'b0);
    wait_idle();

    // SUB borrow: 1 - 3.
    load_a(1); press_opnd(3);
    run_op(1, 4'hE, 4'b1010, 1, 1'b0);
    wait_idle();

    // XOR to zero: 3 ^ 3.
    load_a(3);
    run_op(3, 0, 4'b0001, 1, 1'b0);
    wait_idle();

    // MUL 6*3 with an SPI update mid-operation.
    load_a(6);
    run_op(0, 2, 4'b0010, 5, 1'b1);
    wait_idle();

    // AND with A=F captured during MUL; hold SEND with ready low.
    tx_ready_in = 1'b0;
    run_op(2, 3, 4'b0000, 1, 1'b0);
    cyc(10);
    btn_op[3] = 1'b1; cyc(10);
    btn_op[3] = 1'b0; cyc(10);
    chk("hold_tx_valid", int'(tx_valid_out), 1);
    chk("hold_busy", int'(busy_out), 1);
    chk("hold_tx_data", int'(tx_data_out), 3);
    tx_ready_in = 1'b1;
    wait_idle();
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(busy_out); end
    chk("no_queued_op", cnt, 0);

    // PWM duty: result 3 -> 48 high cycles per 256-cycle period.
    cyc(520);
    cnt = 0;
    repeat (256) begin @(negedge clk); cnt += int'(motor_pwm); end
    chk("pwm_duty_3", cnt, 48);

    // Abort: reset two edges into a MUL.
    btn_op[0] = 1'b1;
    n = 0;
    while (!busy_out && n < 40) begin @(negedge clk); n++; end
    chk("abort_launch", int'(busy_out), 1);
    @(posedge clk);
    @(posedge clk);
    #2 FPGA_reset = 1'b1;
    #1 all_zero("abort");
    btn_op[0] = 1'b0;
    cyc(2);
    FPGA_reset = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(result_valid_out) + int'(tx_valid_out); end
    chk("abort_no_result", cnt, 0);
    cnt = 0;
    repeat (300) begin @(negedge clk); cnt += int'(motor_pwm); end
    chk("abort_pwm_zero", cnt, 0);

    // Randomized phase, checked by the per-cycle model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if ($urandom % 12 == 0) btn_op[b] = ~btn_op[b];
        if ($urandom % 12 == 0) btn_operand_n[b] = ~btn_operand_n[b];
      end
      spi_valid_in = ($urandom % 6 == 0);
      spi_data_in  = W'($urandom);
      tx_ready_in  = ($urandom % 3 != 0);
      if (c == 1500) begin
        #3 FPGA_reset = 1'b1;
        #1 FPGA_reset = 1'b0;
      end
    end
    spi_valid_in = 1'b0;
    btn_op = 4'h0;
    btn_operand_n = 4'hF;
    tx_ready_in = 1'b1;
    cyc(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
